// File: rtl/cpu_pkg.sv
// Shared constants and fetch-stage state encoding for the 16-bit pipelined core.
package cpu_pkg;

  localparam int ADDR_WIDTH  = 16;
  localparam int INSTR_WIDTH = 16;

  localparam logic [ADDR_WIDTH-1:0]  RESET_PC  = 16'h0000;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
module if_id_reg #(
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   hold,
  input  logic                   load,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [ADDR_WIDTH-1:0]  pcplus1_in,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  pcplus1,
  output logic                   valid
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instr   <= NOP_INSTR;
      pcplus1 <= '0;
      valid   <= 1'b0;
    end else if (hold) begin
      instr   <= instr;
      pcplus1 <= pcplus1;
      valid   <= valid;
    end else if (load) begin
      instr   <= instr_in;
      pcplus1 <= pcplus1_in;
      valid   <= 1'b1;
    end else begin
      instr   <= NOP_INSTR;
      pcplus1 <= '0;
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, variable-latency imem handshake, redirects and hazard stalls,
// feeding the IF/ID register.
module fetch_unit #(
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pcstall,
  input  logic                   IF_IDstall,
  input  logic                   flushIF_ID,
  input  logic                   PCSrc,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  input  logic                   jump,
  input  logic [ADDR_WIDTH-1:0]  jump_target,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   imem_stall,
  output logic [INSTR_WIDTH-1:0] instrD,
  output logic [ADDR_WIDTH-1:0]  pcplus1D,
  output logic                   validD
);

  import cpu_pkg::*;

  fetch_state_t           state_reg;
  logic [ADDR_WIDTH-1:0]  pc_reg;
  logic                   redirect_pending_reg;
  logic [ADDR_WIDTH-1:0]  pending_target_reg;
  logic [INSTR_WIDTH-1:0] hold_buf_reg;

  logic                   redirect;
  logic [ADDR_WIDTH-1:0]  target;
  logic [ADDR_WIDTH-1:0]  pcplus1;
  logic                   deliver;
  logic [INSTR_WIDTH-1:0] deliver_instr;

  // The branch resolves further down the pipe, so it is older than the jump.
  assign redirect = PCSrc | jump;
  assign target   = PCSrc ? branch_target : jump_target;
  assign pcplus1  = pc_reg + 1'b1;

  assign deliver = ((state_reg == S_FETCH) && imem_ready && !redirect_pending_reg &&
                    !redirect && !pcstall) ||
                   ((state_reg == S_HOLD) && !redirect && !pcstall);
  assign deliver_instr = (state_reg == S_HOLD) ? hold_buf_reg : imem_rdata;

  assign imem_req   = (state_reg == S_FETCH);
  assign imem_addr  = pc_reg;
  assign imem_stall = imem_req && !imem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg            <= S_IDLE;
      pc_reg               <= RESET_PC;
      redirect_pending_reg <= 1'b0;
      pending_target_reg   <= RESET_PC;
      hold_buf_reg         <= NOP_INSTR;
    end else begin
      case (state_reg)
        S_IDLE: state_reg <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            // A redirect completing alongside a pending one is younger and wins.
            if (redirect_pending_reg || redirect) begin
              pc_reg               <= redirect ? target : pending_target_reg;
              redirect_pending_reg <= 1'b0;
            end else if (pcstall) begin
              hold_buf_reg <= imem_rdata;
              state_reg    <= S_HOLD;
            end else begin
              pc_reg <= pcplus1;
            end
          end else if (redirect) begin
            // imem_addr must stay stable until the outstanding request completes.
            redirect_pending_reg <= 1'b1;
            pending_target_reg   <= target;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc_reg    <= target;
            state_reg <= S_FETCH;
          end else if (!pcstall) begin
            pc_reg    <= pcplus1;
            state_reg <= S_FETCH;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  if_id_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH),
    .NOP_INSTR  (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .flush     (flushIF_ID),
    .hold      (IF_IDstall | pcstall),
    .load      (deliver),
    .instr_in  (deliver_instr),
    .pcplus1_in(pcplus1),
    .instr     (instrD),
    .pcplus1   (pcplus1D),
    .valid     (validD)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios then randomized hazards/redirects/memory latency against a reference model.
module tb_fetch_unit;

  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, pcstall, IF_IDstall, flushIF_ID, PCSrc, jump;
  logic [15:0] branch_target, jump_target;
  logic        imem_req, imem_ready, imem_stall, validD;
  logic [15:0] imem_addr, imem_rdata, instrD, pcplus1D;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .pcstall(pcstall), .IF_IDstall(IF_IDstall),
    .flushIF_ID(flushIF_ID), .PCSrc(PCSrc), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .imem_stall(imem_stall), .instrD(instrD), .pcplus1D(pcplus1D), .validD(validD)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: fetch is either starting up, has a request out, or parks one fetched word.
  bit          m_started, m_parked, m_pend, m_valid;
  logic [15:0] m_pc, m_pend_t, m_park, m_instr, m_pc1;

  // Memory responder
  bit          rand_mem = 1'b0;
  bit          in_req = 1'b0;
  int          wait_left = 0;
  bit          rd_ovr = 1'b0;
  logic [15:0] rd_val = 16'h0;

  task automatic model_reset();
    m_started = 0; m_parked = 0; m_pend = 0; m_valid = 0;
    m_pc = RESET_PC; m_pend_t = RESET_PC; m_park = NOP_INSTR;
    m_instr = NOP_INSTR; m_pc1 = 16'h0;
  endtask

  // One clock: check outputs at negedge, drive inputs, advance model, wait for next negedge.
  task automatic step(input logic r, input logic pcs, input logic ifs, input logic fl,
                      input logic br, input logic [15:0] bt, input logic jp, input logic [15:0] jt);
    bit          exp_req, redir, del;
    logic [15:0] tgt, d_instr, d_pc1;
    exp_req = m_started && !m_parked;
    check_eq("imem_req", imem_req, exp_req);
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("instrD", instrD, m_instr);
    check_eq("pcplus1D", pcplus1D, m_pc1);
    check_eq("validD", validD, m_valid);

    rst = r; pcstall = pcs; IF_IDstall = ifs; flushIF_ID = fl;
    PCSrc = br; branch_target = bt; jump = jp; jump_target = jt;
    if (exp_req) begin
      if (!in_req) begin
        in_req = 1;
        if (rand_mem) wait_left = ($urandom % 2) ? 0 : int'($urandom_range(1, 3));
        else wait_left = (m_pc == 16'd4 || m_pc == 16'd10) ? 3 : 0;
      end
      if (wait_left == 0) begin imem_ready = 1'b1; in_req = 0; end
      else begin imem_ready = 1'b0; wait_left--; end
    end else begin
      // Stray ready while nothing is requested must be ignored.
      imem_ready = rand_mem ? 1'($urandom % 2) : 1'b1;
      in_req = 0;
    end
    imem_rdata = rd_ovr ? rd_val : (rand_mem ? 16'($urandom) : (m_pc ^ 16'hA5A5));
    if (r) in_req = 0;
    #1;
    check_eq("imem_stall", imem_stall, exp_req && !imem_ready);

    redir = br || jp;
    tgt = br ? bt : jt;
    del = 0; d_instr = 16'h0; d_pc1 = 16'h0;
    if (r) begin
      model_reset();
    end else begin
      if (!m_started) begin
        m_started = 1;
      end else if (m_parked) begin
        if (redir) begin m_parked = 0; m_pc = tgt; end
        else if (!pcs) begin
          del = 1; d_instr = m_park; d_pc1 = m_pc + 16'd1;
          m_pc = m_pc + 16'd1; m_parked = 0;
        end
      end else if (imem_ready) begin
        if (m_pend || redir) begin m_pc = redir ? tgt : m_pend_t; m_pend = 0; end
        else if (pcs) begin m_parked = 1; m_park = imem_rdata; end
        else begin
          del = 1; d_instr = imem_rdata; d_pc1 = m_pc + 16'd1;
          m_pc = m_pc + 16'd1;
        end
      end else if (redir) begin
        m_pend = 1; m_pend_t = tgt;
      end
      if (fl) begin m_instr = NOP_INSTR; m_pc1 = 16'h0; m_valid = 0; end
      else if (ifs || pcs) begin end
      else if (del) begin
        m_instr = d_instr; m_pc1 = d_pc1; m_valid = 1;
        $display("load instr=%h pcplus1=%h", d_instr, d_pc1);
      end else begin m_instr = NOP_INSTR; m_pc1 = 16'h0; m_valid = 0; end
    end
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 16'h0, 0, 16'h0);
  endtask

  initial begin
    logic [15:0] bt, jt;
    bit          pcs;
    rst = 1; pcstall = 0; IF_IDstall = 0; flushIF_ID = 0; PCSrc = 0; jump = 0;
    branch_target = 0; jump_target = 0; imem_ready = 0; imem_rdata = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    step(1, 0, 0, 0, 0, 16'h0, 0, 16'h0);

    // Zero-wait stream 0..3, then 3 wait states at address 4.
    for (int i = 0; i < 10; i++) idle_step();
    check_eq("stream_addr_after_wait", imem_addr, 16'd6);

    // Jump, then flush from the bench.
    step(0, 0, 0, 0, 0, 16'h0, 1, 16'h0040);
    check_eq("jump_addr", imem_addr, 16'h0040);
    idle_step();
    step(0, 0, 0, 1, 0, 16'h0, 0, 16'h0);
    check_eq("flush_valid", validD, 1'b0);

    // Branch beats jump.
    step(0, 0, 0, 0, 1, 16'h0100, 1, 16'h0200);
    check_eq("branch_over_jump", imem_addr, 16'h0100);

    // Redirect during an outstanding 3-wait fetch at address 10.
    step(0, 0, 0, 0, 0, 16'h0, 1, 16'd10);
    idle_step();
    step(0, 0, 0, 0, 0, 16'h0, 1, 16'h0080);
    check_eq("pending_addr_stable", imem_addr, 16'd10);
    idle_step();
    idle_step();
    check_eq("pending_drop_valid", validD, 1'b0);
    check_eq("pending_target_addr", imem_addr, 16'h0080);

    // pcstall for two cycles while a word returns.
    rd_ovr = 1; rd_val = 16'h1234;
    step(0, 1, 0, 0, 0, 16'h0, 0, 16'h0);
    check_eq("hold_req", imem_req, 1'b0);
    step(0, 1, 0, 0, 0, 16'h0, 0, 16'h0);
    rd_ovr = 0;
    step(0, 0, 0, 0, 0, 16'h0, 0, 16'h0);
    check_eq("hold_release_instr", instrD, 16'h1234);
    check_eq("hold_release_addr", imem_addr, 16'h0081);

    // Reset in the middle of a waited fetch.
    step(0, 0, 0, 0, 0, 16'h0, 1, 16'd4);
    idle_step();
    step(1, 0, 0, 0, 0, 16'h0, 0, 16'h0);
    check_eq("rst_mid_req", imem_req, 1'b0);
    check_eq("rst_mid_addr", imem_addr, RESET_PC);
    for (int i = 0; i < 4; i++) idle_step();

    // Randomized phase.
    rand_mem = 1;
    for (int i = 0; i < 600; i++) begin
      pcs = ($urandom % 4) == 0;
      bt = ($urandom % 4 == 0) ? 16'hFFFE : 16'($urandom);
      jt = ($urandom % 4 == 0) ? 16'hFFFF : 16'($urandom);
      step(($urandom % 100) == 0, pcs, pcs && ($urandom % 2), ($urandom % 10) == 0,
           ($urandom % 12) == 0, bt, ($urandom % 12) == 0, jt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 16-bit pipelined processor. Sits directly upstream of the hazard unit and the decode stage.
- Owns the PC and runs a variable-latency req/ready handshake to instruction memory. Applies branch/jump redirects and honours the hazard unit's pcstall, IF_IDstall and flushIF_ID.
- Drives imem_stall, which the top level ORs into the hazard unit's stop input.

Parameters:
ADDR_WIDTH, 16, PC / instruction-memory word-address width
INSTR_WIDTH, 16, instruction width
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0000, encoding inserted into IF/ID on bubble or flush

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
pcstall  in  1  hazard unit: hold PC / do not accept fetched instruction
IF_IDstall  in  1  hazard unit: hold IF/ID register contents
flushIF_ID  in  1  hazard unit: load bubble into IF/ID
PCSrc  in  1  branch taken (resolved downstream)
branch_target  in  ADDR_WIDTH  branch destination
jump  in  1  jump decoded in ID
jump_target  in  ADDR_WIDTH  jump destination
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_WIDTH  fetch word address, stable while imem_req=1 and imem_ready=0
imem_ready  in  1  imem_rdata valid this cycle, completes request
imem_rdata  in  INSTR_WIDTH  fetched instruction
imem_stall  out  1  fetch outstanding and not completing this cycle (to stop)
instrD  out  INSTR_WIDTH  IF/ID instruction
pcplus1D  out  ADDR_WIDTH  IF/ID PC+1 of instrD
validD  out  1  IF/ID holds a real instruction

Behaviour:
- Reset values: state=S_IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instrD=NOP_INSTR, pcplus1D=0, validD=0, imem_stall=0, redirect_pending=0. Reset mid-request abandons the request; a late imem_ready after reset is ignored.
- redirect = PCSrc | jump. target = PCSrc ? branch_target : jump_target. PCSrc wins because the branch is older.
- PC arithmetic: pc+1 modulo 2^ADDR_WIDTH; 16'hFFFF wraps to 0.
- S_IDLE: imem_req=0. Next state S_FETCH.
- S_FETCH: imem_req=1, imem_addr=pc. imem_stall = ~imem_ready.
  - Ready with redirect_pending=1: drop data; pc<=pending_target; clear pending; stay.
  - Ready with redirect (same cycle): drop data; pc<=target; stay.
  - Ready with pcstall=1: capture imem_rdata into the hold buffer; go S_HOLD.
  - Ready otherwise (delivery): IF/ID<=imem_rdata, pc+1; pc<=pc+1; stay.
  - Not ready with redirect: pending_target<=target; redirect_pending<=1. pc unchanged, because the address must stay stable. A later redirect overwrites pending_target.
- S_HOLD: imem_req=0, imem_stall=0.
  - redirect: discard buffer; pc<=target; go S_FETCH.
  - pcstall=0: deliver the buffer to IF/ID; pc<=pc+1; go S_FETCH.
  - else: stay.
- IF/ID update priority:
  - flushIF_ID: bubble (instrD=NOP_INSTR, validD=0, pcplus1D=0).
  - else IF_IDstall or pcstall: hold.
  - else delivery: load.
  - else: bubble.
- Latency: zero-wait memory gives one instruction per cycle. An instruction returned at cycle n is visible on instrD at n+1. A redirect at cycle n puts the target on imem_addr at n+1, or one cycle after the outstanding request completes.
- Redirect and pcstall in the same cycle: the redirect still updates pc, because the hazard unit raises pcstall during branch flush.

Decomposition:
- Shared package (cpu_pkg): ADDR_WIDTH, INSTR_WIDTH, NOP_INSTR, RESET_PC, and the fetch state encoding (S_IDLE, S_FETCH, S_HOLD).
- One natural sub-module: if_id_reg, holding the IF/ID register with flush/stall/load priority. The FSM, PC and hold buffer stay in fetch_unit.

Test Plan:
- Reset then zero-wait memory returning addr^16'hA5A5: imem_addr counts 0,1,2,3. instrD shows 16'hA5A5, 16'hA5A4 … one cycle later; validD=1; imem_stall never asserted.
- Memory with 3 wait states at addr 4: imem_addr held at 4 for 4 cycles and imem_stall=1 for 3 cycles. IF/ID inserts bubbles (validD=0), then loads on completion.
- jump=1, jump_target=16'h0040 in a zero-wait stream: next imem_addr=16'h0040. flushIF_ID from the TB gives validD=0 for one cycle.
- PCSrc=1 (branch_target=16'h0100) and jump=1 (jump_target=16'h0200) together → imem_addr=16'h0100.
- Redirect to 16'h0080 at wait cycle 1 of a 3-wait fetch at addr 10: addr stays 10 until ready, and that data is dropped (validD stays 0). Next imem_addr=16'h0080.
- pcstall held 2 cycles while ready returns 16'h1234: state S_HOLD, imem_req=0, instrD held. After release, instrD=16'h1234 and the PC advances. Also check rst asserted mid-wait → imem_req=0, imem_addr=RESET_PC next cycle.
